rs_chien_search_mc: RTL and testbench
=====================================

RS_CHIEN_SEARCH_MC -- requirements
Module: rs_chien_search_mc

Interface
REQ-001 Parameter SYMB_WIDTH, default 8: GF(2^m) symbol width; field arithmetic and primitive polynomial come from gf_pkg.
REQ-002 Parameter T_LEN, default 8: maximum correctable errors; the locator has T_LEN+1 coefficients.
REQ-003 Parameter N_LEN, default 255: codeword length in symbols, range 1 to 2^SYMB_WIDTH-1.
REQ-004 Parameter ROOTS_PER_CYCLE, default 16: roots evaluated per SCAN cycle, range 1 to N_LEN.
REQ-005 aclk  in  1  sole clock; all state updates on the rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 locator  in  SYMB_WIDTH x (T_LEN+1)  error locator coefficients; index 0 is Lambda0.
REQ-008 locator_vld  in  1  locator valid.
REQ-009 locator_rdy  out  1  block can accept a locator.
REQ-010 err_pos  out  SYMB_WIDTH x T_LEN  error locations, packed from slot 0 upward.
REQ-011 err_pos_sel  out  T_LEN  slot-valid mask, contiguous from bit 0.
REQ-012 err_cnt  out  $clog2(T_LEN+1)  number of valid slots.
REQ-013 err_fail  out  1  decoding failure flag.
REQ-014 out_vld  in/out: out  1  result valid.
REQ-015 out_rdy  in  1  downstream accepts the result.

Function
REQ-016 The block SHALL implement the FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE: locator_rdy=1; locator_vld&&locator_rdy registers the locator and moves to SCAN.
- SCAN: locator_rdy=0.
- DONE: out_vld=1 and outputs are held stable; out_vld&&out_rdy returns to IDLE.
REQ-017 Scan cycle k (k=0..C-1, C=ceil(N_LEN/ROOTS_PER_CYCLE)) SHALL evaluate Lambda(alpha^i) for i = k*ROOTS_PER_CYCLE + r, r = 0..ROOTS_PER_CYCLE-1.
REQ-018 In the last cycle, lanes with i >= N_LEN SHALL be masked and never counted.
REQ-019 For each root alpha^i, the reported location SHALL be j = (N_LEN - i) mod N_LEN.
REQ-020 Locations SHALL fill slots in ascending i order, lowest lane first within a cycle.
REQ-021 The block SHALL keep a root counter that saturates at T_LEN+1; roots beyond T_LEN slots SHALL be counted but not stored.
REQ-022 deg SHALL be the highest index with a non-zero coefficient.
REQ-023 err_fail SHALL be 1 if any of the following holds:
- Lambda0 == 0;
- the locator is all zero;
- root count != deg.
Otherwise err_fail SHALL be 0.
REQ-024 When err_fail=1, err_pos_sel SHALL be 0 and err_cnt SHALL be 0.
REQ-025 A locator with deg=0 and Lambda0 != 0 SHALL give err_cnt=0 and err_fail=0.
REQ-026 Without early termination, out_vld SHALL rise exactly C+1 cycles after the accepting edge.
REQ-027 While out_rdy=0 in DONE, all outputs SHALL hold; locator_vld SHALL be ignored until the result is consumed.
REQ-028 Unused err_pos slots SHALL read 0.

Reset
REQ-029 On aresetn=0 the block SHALL return to IDLE and clear all counters and slots.
REQ-030 Reset values: locator_rdy=0 while aresetn=0 and 1 after release; out_vld=0, err_pos_sel=0, err_cnt=0, err_fail=0, err_pos all 0.
REQ-031 Reset asserted during SCAN or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-032 Macro RS_CHIEN_EARLY_TERM_EN: when defined, SCAN SHALL go to DONE at the end of the first cycle in which root count equals deg (deg >= 1). In that case out_vld rises k+2 cycles after accept, where k is that cycle index.
REQ-033 With RS_CHIEN_EARLY_TERM_EN defined, deg=0 with Lambda0 != 0 SHALL go straight to DONE, with out_vld one cycle after accept.
REQ-034 Without RS_CHIEN_EARLY_TERM_EN, the full C-cycle scan SHALL always run; results SHALL be identical either way.

Verification (defaults, C=16)
REQ-035 Lambda=(1+alpha^3x)(1+alpha^10x) -> err_pos[0]=10, err_pos[1]=3, err_pos_sel=0b11, err_cnt=2, err_fail=0, out_vld at accept+17.
REQ-036 Lambda=1+alpha^250x -> err_pos[0]=250, err_cnt=1; out_vld at accept+17 without the macro, accept+2 with RS_CHIEN_EARLY_TERM_EN.
REQ-037 Lambda={1,0,...,0} -> err_cnt=0, err_fail=0; all-zero locator -> err_fail=1; Lambda0=0 with Lambda1=1 -> err_fail=1.
REQ-038 deg=2 irreducible quadratic (no roots in the field) -> err_fail=1, err_pos_sel=0.
REQ-039 Hold out_rdy=0 for 5 cycles in DONE with locator_vld=1 -> outputs stable, locator_rdy=0, and the second locator is accepted only after the handshake.
REQ-040 Assert aresetn=0 mid-SCAN at cycle 7 -> out_vld never asserts; after release locator_rdy=1 and the next locator decodes correctly.

Source files
------------

// File: rtl/rs_chien_search_mc.sv
// rtl/rs_chien_search_mc.sv - multi-root-per-cycle Chien search over GF(2^m); optional early exit via RS_CHIEN_EARLY_TERM_EN
package gf_pkg;
    function automatic int unsigned prim_poly(input int m);
        case (m)
            3:       prim_poly = 32'h0000B;
            4:       prim_poly = 32'h00013;
            5:       prim_poly = 32'h00025;
            6:       prim_poly = 32'h00043;
            7:       prim_poly = 32'h00089;
            9:       prim_poly = 32'h00211;
            10:      prim_poly = 32'h00409;
            11:      prim_poly = 32'h00805;
            12:      prim_poly = 32'h01053;
            13:      prim_poly = 32'h0201B;
            14:      prim_poly = 32'h04443;
            15:      prim_poly = 32'h08003;
            16:      prim_poly = 32'h1100B;
            default: prim_poly = 32'h0011D;
        endcase
    endfunction
endpackage

module rs_chien_search_mc #(
    parameter int SYMB_WIDTH      = 8,
    parameter int T_LEN           = 8,
    parameter int N_LEN           = 255,
    parameter int ROOTS_PER_CYCLE = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [SYMB_WIDTH*(T_LEN+1)-1:0] locator,
    input  logic                            locator_vld,
    output logic                            locator_rdy,
    output logic [SYMB_WIDTH*T_LEN-1:0]     err_pos,
    output logic [T_LEN-1:0]                err_pos_sel,
    output logic [$clog2(T_LEN+1)-1:0]      err_cnt,
    output logic                            err_fail,
    output logic                            out_vld,
    input  logic                            out_rdy
);
    localparam int SW = SYMB_WIDTH;
    localparam int R  = ROOTS_PER_CYCLE;
    localparam int C  = (N_LEN + R - 1) / R;
    localparam int Q  = (1 << SW) - 1;
    localparam int KW = $clog2(C) + 1;
    localparam int CW = $clog2(T_LEN + 2);
    localparam int DW = $clog2(T_LEN + 1);
    localparam logic [SW-1:0] PRIM_LO = SW'(gf_pkg::prim_poly(SW));
`ifdef RS_CHIEN_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] p;
        logic [SW-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SW; i++) begin
            if (b[i]) p = p ^ x;
            x = x[SW-1] ? ((x << 1) ^ PRIM_LO) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [SW-1:0] alpha_pow(input int e);
        logic [SW-1:0] p;
        p = SW'(1);
        for (int i = 0; i < e; i++) p = p[SW-1] ? ((p << 1) ^ PRIM_LO) : (p << 1);
        return p;
    endfunction

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    term_q  [T_LEN+1];
    logic [SW-1:0]    term_nx [T_LEN+1];
    logic [SW-1:0]    prod    [R][T_LEN+1];
    logic [SW-1:0]    slot_q  [T_LEN];
    logic [SW-1:0]    slot_nx [T_LEN];
    logic [KW-1:0]    k_q;
    logic [CW-1:0]    cnt_q, cnt_nx;
    logic [DW-1:0]    deg_q, deg_in, ecnt_q;
    logic [T_LEN-1:0] sel_q, sel_nx;
    logic             lam0_zero_q, fin_q, fail_q, et_hit, fail_nx;

    // term_q[j] holds Lambda_j * alpha^(j*k*R); lane r adds the fixed alpha^(j*r) offset.
    for (genvar j = 0; j <= T_LEN; j++) begin : g_coef
        localparam logic [SW-1:0] STEP = alpha_pow((j * R) % Q);
        assign term_nx[j] = gf_mul(term_q[j], STEP);
        for (genvar r = 0; r < R; r++) begin : g_lane
            localparam logic [SW-1:0] LANE = alpha_pow((j * r) % Q);
            assign prod[r][j] = gf_mul(term_q[j], LANE);
        end
    end

    always_comb begin
        deg_in = '0;
        for (int j = 1; j <= T_LEN; j++)
            if (locator[j*SW +: SW] != '0) deg_in = DW'(j);
    end

    always_comb begin
        logic [SW-1:0] val;
        int            idx;
        val     = '0;
        idx     = 0;
        cnt_nx  = cnt_q;
        slot_nx = slot_q;
        for (int r = 0; r < R; r++) begin
            val = '0;
            for (int j = 0; j <= T_LEN; j++) val = val ^ prod[r][j];
            idx = int'(k_q) * R + r;
            if (val == '0 && idx < N_LEN) begin
                for (int s = 0; s < T_LEN; s++)
                    if (cnt_nx == CW'(s)) slot_nx[s] = (idx == 0) ? '0 : SW'(N_LEN - idx);
                if (cnt_nx <= CW'(T_LEN)) cnt_nx = cnt_nx + CW'(1);
            end
        end
        et_hit  = EARLY_TERM && deg_q != '0 && cnt_nx == CW'(deg_q);
        fail_nx = lam0_zero_q || (cnt_q != CW'(deg_q));
        for (int s = 0; s < T_LEN; s++) sel_nx[s] = CW'(s) < cnt_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        locator_rdy = 1'b0;
        out_vld     = 1'b0;
        case (state)
            IDLE: begin
                locator_rdy = aresetn;
                if (locator_vld) state_nx = SCAN;
            end
            SCAN: if (fin_q) state_nx = DONE;
            DONE: begin
                out_vld = 1'b1;
                if (out_rdy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // fin_q marks the extra SCAN cycle that turns the root count into the verdict.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int j = 0; j <= T_LEN; j++) term_q[j] <= '0;
            for (int s = 0; s < T_LEN; s++) slot_q[s] <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            deg_q       <= '0;
            lam0_zero_q <= 1'b0;
            fin_q       <= 1'b0;
            sel_q       <= '0;
            ecnt_q      <= '0;
            fail_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (locator_vld) begin
                    for (int j = 0; j <= T_LEN; j++) term_q[j] <= locator[j*SW +: SW];
                    for (int s = 0; s < T_LEN; s++) slot_q[s] <= '0;
                    k_q         <= '0;
                    cnt_q       <= '0;
                    deg_q       <= deg_in;
                    lam0_zero_q <= (locator[SW-1:0] == '0);
                    fin_q       <= EARLY_TERM && deg_in == '0 && locator[SW-1:0] != '0;
                    sel_q       <= '0;
                    ecnt_q      <= '0;
                    fail_q      <= 1'b0;
                end
                SCAN: if (fin_q) begin
                    fin_q  <= 1'b0;
                    fail_q <= fail_nx;
                    sel_q  <= fail_nx ? '0 : sel_nx;
                    ecnt_q <= fail_nx ? '0 : DW'(cnt_q);
                    if (fail_nx)
                        for (int s = 0; s < T_LEN; s++) slot_q[s] <= '0;
                end else begin
                    for (int j = 0; j <= T_LEN; j++) term_q[j] <= term_nx[j];
                    for (int s = 0; s < T_LEN; s++) slot_q[s] <= slot_nx[s];
                    cnt_q <= cnt_nx;
                    k_q   <= k_q + KW'(1);
                    fin_q <= (k_q == KW'(C - 1)) || et_hit;
                end
                default: ;
            endcase
        end
    end

    for (genvar s = 0; s < T_LEN; s++) begin : g_out
        assign err_pos[s*SW +: SW] = slot_q[s];
    end
    assign err_pos_sel = sel_q;
    assign err_cnt     = ecnt_q;
    assign err_fail    = fail_q;
endmodule

// File: tb/tb_rs_chien_search_mc.sv
// tb/tb_rs_chien_search_mc.sv - randomized self-checking bench for rs_chien_search_mc
module tb_rs_chien_search_mc;
    localparam int SW = 8;
    localparam int T  = 8;
    localparam int N  = 255;
    localparam int R  = 16;
    localparam int C  = (N + R - 1) / R;
    localparam int LW = SW * (T + 1);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [LW-1:0] locator = '0;
    logic          locator_vld = 1'b0;
    logic          locator_rdy;
    logic [SW*T-1:0] err_pos;
    logic [T-1:0]  err_pos_sel;
    logic [3:0]    err_cnt;
    logic          err_fail;
    logic          out_vld;
    logic          out_rdy = 1'b0;

    always #5 aclk = ~aclk;

    rs_chien_search_mc dut (
        .aclk(aclk), .aresetn(aresetn), .locator(locator), .locator_vld(locator_vld),
        .locator_rdy(locator_rdy), .err_pos(err_pos), .err_pos_sel(err_pos_sel),
        .err_cnt(err_cnt), .err_fail(err_fail), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    int total = 0;
    int bad = 0;
    int exp_t [0:254];
    int log_t [0:255];
    int m_pos [T];
    int m_sel, m_cnt, m_fail, m_lat;
    bit exp_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic int coef(input logic [LW-1:0] lam, input int j);
        return int'(lam[j*SW +: SW]);
    endfunction

    // Brute-force reference: evaluate Lambda at every alpha^i by Horner's rule.
    task automatic model(input logic [LW-1:0] lam);
        int deg, roots, acc, lam0;
        deg = 0;
        for (int j = 0; j <= T; j++) if (coef(lam, j) != 0) deg = j;
        lam0 = coef(lam, 0);
        roots = 0;
        for (int s = 0; s < T; s++) m_pos[s] = 0;
        m_lat = C + 1;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = T; j >= 0; j--) acc = gmul(acc, exp_t[i % 255]) ^ coef(lam, j);
            if (acc == 0) begin
                if (roots < T) m_pos[roots] = (N - i) % N;
                if (roots <= T) roots++;
`ifdef RS_CHIEN_EARLY_TERM_EN
                if (deg >= 1 && roots == deg && m_lat == C + 1) m_lat = i / R + 2;
`endif
            end
        end
`ifdef RS_CHIEN_EARLY_TERM_EN
        if (deg == 0 && lam0 != 0) m_lat = 1;
`endif
        m_fail = (lam0 == 0 || roots != deg) ? 1 : 0;
        if (m_fail != 0) begin
            m_sel = 0;
            m_cnt = 0;
            for (int s = 0; s < T; s++) m_pos[s] = 0;
        end else begin
            m_cnt = roots;
            m_sel = (1 << roots) - 1;
        end
    endtask

    function automatic logic [LW-1:0] build_lambda(input int locs[$], input int scale);
        int p [T+1];
        int nw [T+1];
        logic [LW-1:0] v;
        foreach (p[j]) p[j] = 0;
        p[0] = scale;
        foreach (locs[q]) begin
            nw[0] = p[0];
            for (int j = 1; j <= T; j++) nw[j] = p[j] ^ gmul(exp_t[locs[q] % 255], p[j-1]);
            p = nw;
        end
        v = '0;
        for (int j = 0; j <= T; j++) v[j*SW +: SW] = p[j][SW-1:0];
        return v;
    endfunction

    always @(negedge aclk) begin
        if (aresetn && out_vld) begin
            chk("out_vld_expected", out_vld, exp_valid);
            if (exp_valid) begin
                for (int s = 0; s < T; s++)
                    chk($sformatf("err_pos[%0d]", s), err_pos[s*SW +: SW], m_pos[s]);
                chk("err_pos_sel", err_pos_sel, m_sel);
                chk("err_cnt", err_cnt, m_cnt);
                chk("err_fail", err_fail, m_fail);
                chk("locator_rdy_in_done", locator_rdy, 0);
            end
        end
    end

    task automatic decode(input logic [LW-1:0] lam, input int hold, input bit nxt_vld,
                          input logic [LW-1:0] nxt);
        int n;
        model(lam);
        locator = lam;
        locator_vld = 1'b1;
        n = 0;
        while (!locator_rdy && n < 50) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("locator_rdy_before_accept", locator_rdy, 1);
        @(posedge aclk); #1;
        exp_valid = 1'b1;
        locator_vld = 1'b0;
        n = 0;
        while (!out_vld && n < 64) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("latency", n, m_lat);
        for (int h = 0; h < hold; h++) begin
            if (nxt_vld) begin
                locator = nxt;
                locator_vld = 1'b1;
            end
            @(posedge aclk); #1;
            chk("hold_out_vld", out_vld, 1);
        end
        if (nxt_vld) begin
            locator = nxt;
            locator_vld = 1'b1;
        end
        out_rdy = 1'b1;
        @(posedge aclk); #1;
        out_rdy = 1'b0;
        exp_valid = 1'b0;
        chk("out_vld_after_handshake", out_vld, 0);
    endtask

    initial begin
        int v, d, l, seen, kind;
        int q[$];
        bit used [N];
        logic [LW-1:0] lam, lam_b;

        v = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if ((v & 256) != 0) v = v ^ 'h11D;
        end
        log_t[0] = 0;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_locator_rdy", locator_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_err_pos", err_pos, 0);
        chk("rst_err_pos_sel", err_pos_sel, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_fail", err_fail, 0);
        aresetn = 1'b1;
        #1;
        chk("rdy_after_release", locator_rdy, 1);
        @(posedge aclk); #1;

        q.delete(); q.push_back(3); q.push_back(10);
        lam = build_lambda(q, 1);
        model(lam);
        chk("pin_two_pos0", m_pos[0], 10);
        chk("pin_two_pos1", m_pos[1], 3);
        chk("pin_two_sel", m_sel, 3);
        chk("pin_two_cnt", m_cnt, 2);
        chk("pin_two_lat", m_lat, 17);
        decode(lam, 0, 1'b0, '0);

        q.delete(); q.push_back(250);
        lam = build_lambda(q, 1);
        model(lam);
        chk("pin_one_pos0", m_pos[0], 250);
        chk("pin_one_cnt", m_cnt, 1);
`ifdef RS_CHIEN_EARLY_TERM_EN
        chk("pin_one_lat", m_lat, 2);
`else
        chk("pin_one_lat", m_lat, 17);
`endif
        decode(lam, 2, 1'b0, '0);

        lam = '0; lam[7:0] = 8'd1;
        model(lam);
        chk("pin_const_fail", m_fail, 0);
        chk("pin_const_cnt", m_cnt, 0);
        decode(lam, 1, 1'b0, '0);

        lam = '0;
        model(lam);
        chk("pin_zero_fail", m_fail, 1);
        decode(lam, 0, 1'b0, '0);

        lam = '0; lam[15:8] = 8'd1;
        model(lam);
        chk("pin_l0zero_fail", m_fail, 1);
        decode(lam, 0, 1'b0, '0);

        // location 0 exercises the masked lane i=255, which aliases alpha^0
        q.delete(); q.push_back(0); q.push_back(1);
        decode(build_lambda(q, 7), 0, 1'b0, '0);

        for (int c = 1; c < 256; c++) begin
            lam = '0;
            lam[7:0] = c[7:0]; lam[15:8] = 8'd1; lam[23:16] = 8'd1;
            model(lam);
            if (m_fail != 0) break;
        end
        chk("pin_quad_sel", m_sel, 0);
        decode(lam, 0, 1'b0, '0);

        q.delete(); q.push_back(17); q.push_back(99); q.push_back(200);
        lam = build_lambda(q, 1);
        q.delete(); q.push_back(42);
        lam_b = build_lambda(q, 3);
        decode(lam, 5, 1'b1, lam_b);
        decode(lam_b, 0, 1'b0, '0);

        q.delete(); q.push_back(120); q.push_back(5);
        lam = build_lambda(q, 1);
        locator = lam;
        locator_vld = 1'b1;
        @(posedge aclk); #1;
        locator_vld = 1'b0;
        repeat (7) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("abort_rdy_in_reset", locator_rdy, 0);
        chk("abort_out_vld_in_reset", out_vld, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        #1;
        chk("abort_rdy_after_release", locator_rdy, 1);
        seen = 0;
        for (int c = 0; c < C + 5; c++) begin
            @(posedge aclk); #1;
            if (out_vld) seen++;
        end
        chk("abort_no_result", seen, 0);
        decode(lam, 0, 1'b0, '0);

        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            q.delete();
            foreach (used[u]) used[u] = 1'b0;
            d = $urandom_range(0, T);
            while (q.size() < d) begin
                l = $urandom_range(0, N - 1);
                if (!used[l]) begin
                    used[l] = 1'b1;
                    q.push_back(l);
                end
            end
            lam = build_lambda(q, $urandom_range(1, 255));
            if (kind == 2) begin
                for (int j = 0; j <= T; j++) lam[j*SW +: SW] = 8'($urandom_range(0, 255));
            end else if (kind == 3) begin
                l = $urandom_range(0, T);
                lam[l*SW +: SW] = lam[l*SW +: SW] ^ 8'($urandom_range(1, 255));
            end
            decode(lam, $urandom_range(0, 3), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
